// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one byte-level SPI master between NUM_REQ requesters.
// Round-robin ownership, combinational forwarding of the owner's handshake and
// data, per-device active-low chip selects, a guard gap between owners and a
// watchdog that takes the bus back from a requester that stops making progress.
module spi_bus_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  input  logic [NUM_REQ-1:0]   req_begin,
  input  logic [8*NUM_REQ-1:0] req_send_data,
  input  logic [NUM_REQ-1:0]   req_ss,
  output logic [NUM_REQ-1:0]   req_end,
  output logic [7:0]           rx_data,
  output logic                 begin_transmission,
  output logic [7:0]           send_data,
  input  logic                 end_transmission,
  input  logic [7:0]           recieved_data,
  output logic [NUM_REQ-1:0]   ss_n,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GUARD
  } state_t;

  state_t        state;
  logic [IW-1:0] g;
  logic [IW-1:0] last;
  logic          in_flight;
  logic          begin_prev;
  logic [15:0]   wd_cnt;
  logic [15:0]   guard_cnt;

  logic          pick_valid;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          begin_rise;

  assign rx_data    = recieved_data;
  assign begin_rise = begin_transmission & ~begin_prev;

  // Round-robin search: first requester after the previous owner, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      cand = IW'((int'(last) + i) % int'(NUM_REQ));
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  // Zero-latency mux between the owner and the master; idle values otherwise.
  always_comb begin
    begin_transmission = 1'b0;
    send_data          = '0;
    ss_n               = '1;
    req_end            = '0;
    if (state == GRANT) begin
      begin_transmission = req_begin[g];
      send_data          = req_send_data[8*g +: 8];
      ss_n[g]            = req_ss[g];
      req_end[g]         = end_transmission;
    end
  end

  // Ownership FSM with byte tracking, watchdog and guard-gap counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      g           <= '0;
      last        <= IW'(NUM_REQ - 1);
      in_flight   <= 1'b0;
      begin_prev  <= 1'b0;
      wd_cnt      <= '0;
      guard_cnt   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      begin_prev  <= begin_transmission;
      case (state)
        IDLE: begin
          in_flight <= 1'b0;
          if (pick_valid) begin
            g           <= pick;
            last        <= pick;
            grant       <= '0;
            grant[pick] <= 1'b1;
            wd_cnt      <= '0;
            state       <= GRANT;
            busy        <= 1'b1;
          end
        end
        GRANT: begin
          if (end_transmission) begin
            in_flight <= 1'b0;
          end else if (begin_rise) begin
            in_flight <= 1'b1;
          end
          if ((!req[g] && !in_flight) || (!end_transmission && wd_cnt == TIMEOUT)) begin
            grant       <= '0;
            in_flight   <= 1'b0;
            guard_cnt   <= '0;
            timeout_err <= req[g] || in_flight;
            if (GUARD_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GUARD;
              busy  <= 1'b1;
            end
          end else if (end_transmission) begin
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        GUARD: begin
          in_flight <= 1'b0;
          if (guard_cnt == GUARD_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed scenarios followed by randomized traffic, every
// cycle compared against a behavioural model of the bus-sharing rules.
module tb_spi_bus_arbiter;

  localparam int          NUM_REQ      = 2;
  localparam int          GUARD_CYCLES = 4;
  localparam logic [15:0] TIMEOUT      = 16'd16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  grant;
  logic [1:0]  req_begin;
  logic [15:0] req_send_data;
  logic [1:0]  req_ss;
  logic [1:0]  req_end;
  logic [7:0]  rx_data;
  logic        begin_transmission;
  logic [7:0]  send_data;
  logic        end_transmission;
  logic [7:0]  recieved_data;
  logic [1:0]  ss_n;
  logic        busy;
  logic        timeout_err;

  int vectors     = 0;
  int miscompares = 0;

  // Model: who owns the bus, how many busy-but-unowned cycles remain, etc.
  bit       m_has;
  bit [0:0] m_idx;
  int       m_gap;
  int       m_last;
  int       m_silent;
  bit       m_open;
  bit       m_prev_begin;
  bit       m_to;

  int         zero_run;
  logic [1:0] obs_grant;
  logic [1:0] obs_end;
  logic       obs_to;

  always #5 clk = ~clk;

  spi_bus_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .GUARD_CYCLES(GUARD_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .grant             (grant),
    .req_begin         (req_begin),
    .req_send_data     (req_send_data),
    .req_ss            (req_ss),
    .req_end           (req_end),
    .rx_data           (rx_data),
    .begin_transmission(begin_transmission),
    .send_data         (send_data),
    .end_transmission  (end_transmission),
    .recieved_data     (recieved_data),
    .ss_n              (ss_n),
    .busy              (busy),
    .timeout_err       (timeout_err)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_has        = 1'b0;
    m_idx        = 1'b0;
    m_gap        = 0;
    m_last       = NUM_REQ - 1;
    m_silent     = 0;
    m_open       = 1'b0;
    m_prev_begin = 1'b0;
    m_to         = 1'b0;
  endtask

  task automatic model_release(input bit forced);
    m_has  = 1'b0;
    m_open = 1'b0;
    m_gap  = (GUARD_CYCLES > 0) ? GUARD_CYCLES + 1 : 0;
    m_to   = forced;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit fwd;
    bit found;
    fwd = m_has && req_begin[m_idx];
    if (rst) begin
      model_reset();
      return;
    end
    m_to = 1'b0;
    if (m_has) begin
      if (!req[m_idx] && !m_open) begin
        model_release(1'b0);
      end else if (!end_transmission && m_silent == int'(TIMEOUT)) begin
        model_release(1'b1);
      end else begin
        m_silent = end_transmission ? 0 : m_silent + 1;
        if (end_transmission) m_open = 1'b0;
        else if (fwd && !m_prev_begin) m_open = 1'b1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      found = 1'b0;
      for (int off = 1; off <= NUM_REQ; off++) begin
        int c;
        c = (m_last + off) % NUM_REQ;
        if (!found && req[c]) begin
          found    = 1'b1;
          m_has    = 1'b1;
          m_idx    = 1'(c);
          m_last   = c;
          m_silent = 0;
          m_open   = 1'b0;
        end
      end
    end
    m_prev_begin = fwd;
  endtask

  // One clock cycle: compare outputs against the model, then cross the edge.
  task automatic applyStimulus(input bit chk);
    logic [1:0] e_grant, e_ss, e_end;
    logic [7:0] e_data;
    logic       e_begin, e_busy;
    #1;
    e_grant = m_has ? (2'b01 << m_idx) : 2'b00;
    e_ss    = 2'b11;
    if (m_has) e_ss[m_idx] = req_ss[m_idx];
    e_end   = (m_has && end_transmission) ? (2'b01 << m_idx) : 2'b00;
    e_begin = m_has && req_begin[m_idx];
    e_data  = m_has ? req_send_data[8*m_idx +: 8] : 8'h00;
    e_busy  = m_has || (m_gap > 0);
    if (chk) begin
      checkOutput("grant", 16'(grant), 16'(e_grant));
      checkOutput("ss_n", 16'(ss_n), 16'(e_ss));
      checkOutput("req_end", 16'(req_end), 16'(e_end));
      checkOutput("begin_transmission", 16'(begin_transmission), 16'(e_begin));
      checkOutput("send_data", 16'(send_data), 16'(e_data));
      checkOutput("rx_data", 16'(rx_data), 16'(recieved_data));
      checkOutput("busy", 16'(busy), 16'(e_busy));
      checkOutput("timeout_err", 16'(timeout_err), 16'(m_to));
      obs_grant = grant;
      obs_end   = req_end;
      obs_to    = timeout_err;
      if (grant === 2'b00) zero_run++;
      else zero_run = 0;
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_owner(input int k, input int limit);
    int n;
    n = 0;
    while (!(m_has && m_idx == 1'(k)) && n < limit) begin
      applyStimulus(1'b1);
      n++;
    end
    #1;
    checkOutput("grant_owner", 16'(grant), 16'(2'b01 << k));
  endtask

  task automatic byte_xfer(input int k, input logic [7:0] data, input logic [7:0] rx,
                           input int wait_cycles, input bit check_route);
    req_send_data[8*k +: 8] = data;
    req_ss[k]    = 1'b0;
    req_begin[k] = 1'b1;
    applyStimulus(1'b1);
    req_begin[k] = 1'b0;
    repeat (wait_cycles) applyStimulus(1'b1);
    end_transmission = 1'b1;
    recieved_data    = rx;
    if (check_route) begin
      #1;
      checkOutput("route_send_data", 16'(send_data), 16'(data));
      checkOutput("route_req_end", 16'(req_end), 16'(2'b01 << k));
      checkOutput("route_rx_data", 16'(rx_data), 16'(rx));
    end
    applyStimulus(1'b1);
    end_transmission = 1'b0;
    applyStimulus(1'b1);
  endtask

  // Hard stop in case the run wedges.
  initial begin
    #200000;
    $display("[TB] FAIL global_time_limit observed=expired expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Directed scenarios, then randomized traffic.
  initial begin
    int cnt;
    int n;
    rst              = 1'b1;
    req              = 2'b11;
    req_begin        = 2'b00;
    req_send_data    = 16'h0000;
    req_ss           = 2'b11;
    end_transmission = 1'b0;
    recieved_data    = 8'h00;
    zero_run         = 0;
    obs_grant        = 2'b00;
    obs_end          = 2'b00;
    obs_to           = 1'b0;
    model_reset();
    @(negedge clk);

    applyStimulus(1'b0);
    #1;
    checkOutput("reset_grant", 16'(grant), 16'h0);
    checkOutput("reset_ss_n", 16'(ss_n), 16'h3);
    checkOutput("reset_begin", 16'(begin_transmission), 16'h0);
    checkOutput("reset_send_data", 16'(send_data), 16'h0);
    checkOutput("reset_req_end", 16'(req_end), 16'h0);
    checkOutput("reset_busy", 16'(busy), 16'h0);
    checkOutput("reset_timeout_err", 16'(timeout_err), 16'h0);
    applyStimulus(1'b1);
    rst = 1'b0;
    applyStimulus(1'b1);
    #1;
    checkOutput("first_grant", 16'(grant), 16'h1);

    for (int k = 0; k < 4; k++) begin
      int who;
      who = k % 2;
      wait_owner(who, 40);
      if (k > 0) checkOutput("guard_gap", 16'(zero_run), 16'(GUARD_CYCLES + 2));
      byte_xfer(who, (who == 1) ? 8'hE8 : 8'($urandom), 8'h5A, 2, who == 1);
      byte_xfer(who, 8'($urandom), 8'($urandom), 1, 1'b0);
      req_ss[who] = 1'b1;
      req[who]    = 1'b0;
      applyStimulus(1'b1);
      req[who]    = 1'b1;
      applyStimulus(1'b1);
    end

    wait_owner(0, 40);
    req_ss[0]    = 1'b0;
    req_begin[0] = 1'b1;
    applyStimulus(1'b1);
    req_begin[0] = 1'b0;
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    req[0] = 1'b0;
    for (int c = 3; c < 10; c++) applyStimulus(1'b1);
    end_transmission = 1'b1;
    recieved_data    = 8'($urandom);
    #1;
    checkOutput("defer_held_at_end", 16'(grant), 16'h1);
    checkOutput("defer_req_end", 16'(req_end), 16'h1);
    applyStimulus(1'b1);
    end_transmission = 1'b0;
    #1;
    checkOutput("defer_held_after_end", 16'(grant), 16'h1);
    applyStimulus(1'b1);
    #1;
    checkOutput("defer_released", 16'(grant), 16'h0);
    checkOutput("defer_guard_busy", 16'(busy), 16'h1);
    req_ss[0] = 1'b1;

    req = 2'b10;
    wait_owner(1, 40);
    req_ss[1]    = 1'b0;
    req_begin[1] = 1'b1;
    cnt = 0;
    n   = 0;
    obs_to = 1'b0;
    while (!obs_to && n < 60) begin
      applyStimulus(1'b1);
      if (obs_grant === 2'b10) cnt++;
      n++;
    end
    checkOutput("timeout_grant_cycles", 16'(cnt), 16'(int'(TIMEOUT) + 1));
    checkOutput("timeout_pulse_grant", 16'(obs_grant), 16'h0);
    end_transmission = 1'b1;
    applyStimulus(1'b1);
    end_transmission = 1'b0;
    checkOutput("timeout_pulse_width", 16'(obs_to), 16'h0);
    checkOutput("timeout_stray_end", 16'(obs_end), 16'h0);
    wait_owner(1, 40);

    applyStimulus(1'b1);
    applyStimulus(1'b1);
    rst = 1'b1;
    applyStimulus(1'b1);
    rst = 1'b0;
    #1;
    checkOutput("midreset_grant", 16'(grant), 16'h0);
    checkOutput("midreset_ss_n", 16'(ss_n), 16'h3);
    checkOutput("midreset_begin", 16'(begin_transmission), 16'h0);
    checkOutput("midreset_busy", 16'(busy), 16'h0);

    for (int i = 0; i < 600; i++) begin
      int bit_sel;
      if ($urandom_range(7) == 0) begin
        bit_sel      = int'($urandom_range(1));
        req[bit_sel] = ~req[bit_sel];
      end
      req_begin        = 2'($urandom) & 2'($urandom);
      req_ss           = 2'($urandom);
      req_send_data    = 16'($urandom);
      end_transmission = (i < 300) ? ($urandom_range(5) == 0) : ($urandom_range(39) == 0);
      recieved_data    = 8'($urandom);
      rst              = ($urandom_range(199) == 0);
      applyStimulus(1'b1);
    end
    rst = 1'b0;
    applyStimulus(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
